// File: rtl/mac_vector_unit.sv
// Dot-product MAC over VEC_LEN unsigned operand pairs; one pair per accepted beat, result held until out_ready.
// Result valid one cycle after the last beat; in_ready low outside ACCUM, result held in DONE under backpressure.
module mac_vector_unit #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int VEC_LEN  = 4,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    count;
    logic                beat;
    logic [2*DATA_W-1:0] product;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    acc_next;

    // One spare bit on the sum exposes the carry-out used for overflow detection.
    always_comb begin
        product  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        sum      = {1'b0, acc} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, product};
        acc_next = sum[ACC_W-1:0];
        if (sum[ACC_W] && (SATURATE != 0)) begin
            acc_next = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = ACCUM;
                ACCUM:   if (beat && count == LAST) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state == ACCUM);
        result_valid = (state == DONE);
        busy         = (state != IDLE);
        beat         = in_valid && (state == ACCUM);
        result       = acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear || (state == IDLE && start)) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (beat) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (sum[ACC_W]) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mac_vector_unit.md
Name: mac_vector_unit

Overview:
- Parametrised multiply-accumulate engine: computes the dot product of two VEC_LEN-element unsigned vectors streamed one element pair per beat.
- Generalises the single-register MAC stage with configurable data/accumulator widths, a beat counter, a valid/ready handshake, result hand-off and selectable saturation.
- Sits between the operand fetch stage and the result writeback stage in the processor datapath.

Parameters:
- DATA_W, 8, width of each operand a, b (unsigned)
- ACC_W, 20, accumulator/result width; must be >= 2*DATA_W
- VEC_LEN, 4, element pairs per dot product; >= 1
- SATURATE, 1, 1 = clamp at 2^ACC_W-1 on overflow; 0 = wrap modulo 2^ACC_W

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  begin a new dot product (sampled in IDLE only)
- clear  in  1  synchronous abort: discard the current operation and return to IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit accepts an operand pair this cycle
- a  in  DATA_W  operand A
- b  in  DATA_W  operand B
- result  out  ACC_W  accumulated dot product
- result_valid  out  1  result is held and valid
- out_ready  in  1  downstream accepts result
- overflow  out  1  sticky; set if any accumulate overflowed during the current operation
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, count=0, overflow=0. Therefore result=0, result_valid=0, in_ready=0, busy=0.
- FSM states:
  - IDLE: start=1 -> ACCUM; same edge acc<=0, count<=0, overflow<=0.
  - ACCUM: in_ready=1. Beat = in_valid & in_ready. On a beat: acc<=acc_next, count<=count+1. Beat with count==VEC_LEN-1 -> DONE. No beat: hold all state.
  - DONE: result_valid=1, result=acc, in_ready=0. out_ready=1 -> IDLE. acc and overflow hold until the next start.
- Arithmetic:
  - product = a*b, 2*DATA_W bits, zero-extended to ACC_W+1 bits.
  - sum = acc + product, ACC_W+1 bits.
  - If sum[ACC_W]=1: overflow<=1, and acc_next = all-ones (SATURATE=1) or sum[ACC_W-1:0] (SATURATE=0).
  - Once saturated, further beats keep acc at max.
- Latency: result_valid rises the cycle after the edge that accepts the last beat. Minimum start-to-result time is VEC_LEN+1 cycles.
- result is driven from acc in every state, but is meaningful only while result_valid=1.
- Boundary conditions:
  - start while busy: ignored.
  - start and out_ready both high in DONE: go to IDLE only; the new start must be reasserted in IDLE.
  - clear has priority over start, beat and out_ready in every non-IDLE state: state<=IDLE, count<=0, acc<=0, overflow<=0. clear in IDLE has the same register effect and blocks start in that cycle.
  - VEC_LEN=1: a single beat goes straight to DONE.
  - in_valid gaps in ACCUM: no accumulation, count held.
  - Operands are ignored when in_ready=0 (IDLE, DONE).
  - rst mid-operation: immediate return to reset values regardless of clk; any partial sum is lost.
- count width is $clog2(VEC_LEN+1). No X on outputs after reset.

Test Plan:
- Defaults. rst pulse, start, beats a={1,2,3,4}, b={5,6,7,8} back-to-back, out_ready=1 -> result_valid on cycle 5 after start accept, result=70, overflow=0, then IDLE.
- Bubbles and backpressure. Same vectors with in_valid low for 2 cycles between beats 2 and 3, and out_ready held low 3 cycles in DONE -> result=70 held stable with result_valid=1 for 4 cycles; in_ready=0 throughout DONE.
- Saturation. ACC_W=16, SATURATE=1, four beats a=b=255 -> result=65535, overflow=1. With SATURATE=0 -> result=63492 (260100 mod 65536), overflow=1.
- Clear and restart. clear after beat 2 -> next cycle busy=0, result=0, overflow=0. A new start with a={1,1,1,1}, b={2,2,2,2} -> result=8.
- start while busy. start asserted during ACCUM and during DONE -> no restart; count and acc unaffected, result=70 for the default vectors.
- Async reset. rst asserted between clock edges after beat 3 -> busy, result_valid, in_ready and result all 0 immediately. After release, a fresh run gives result=70.
